// File: rtl/modn_sched_pkg.sv
// Shared types for the mod-N step scheduler: FSM state encoding and requester ids.
package modn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    typedef enum logic {
        REQ_UP = 1'b0,
        REQ_DN = 1'b1
    } req_id_t;

    localparam int STATE_W = 2;

endpackage

// File: rtl/modn_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module modn_rr_arb
    import modn_sched_pkg::*;
(
    input  logic       up_req,
    input  logic       dn_req,
    input  logic       last,
    output logic [1:0] gnt
);

    // gnt[0] = up, gnt[1] = dn
    always_comb begin
        gnt = 2'b00;
        if (up_req && dn_req) begin
            gnt = (last == REQ_DN) ? 2'b01 : 2'b10;
        end else if (up_req) begin
            gnt = 2'b01;
        end else if (dn_req) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/modn_step_scheduler.sv
// Grants step bursts of a mod-N counter to an up and a down requester.
// Optional abort input is enabled with MODN_SCHED_ABORT_EN.
module modn_step_scheduler
    import modn_sched_pkg::*;
#(
    parameter int N     = 10,
    parameter int MSB   = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             up_req,
    input  logic             dn_req,
    input  logic [LEN_W-1:0] up_len,
    input  logic [LEN_W-1:0] dn_len,
    input  logic [MSB-1:0]   cnt_val,
`ifdef MODN_SCHED_ABORT_EN
    input  logic             abort,
`endif
    output logic             up_gnt,
    output logic             dn_gnt,
    output logic             up_done,
    output logic             dn_done,
    output logic             step_en,
    output logic             step_up,
    output logic             wrap,
    output logic [1:0]       dbg_state
);

    // Handshake: req is a level held by the requester; the winner's len must be
    // valid during its one-cycle gnt pulse, after which req and len are ignored
    // until the matching done pulse.
    sched_state_t     state, state_nxt;
    req_id_t          served, last;
    logic             dir_up;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_sel;
    logic [1:0]       arb_gnt;
    logic             abort_hit;

`ifdef MODN_SCHED_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    modn_rr_arb u_arb (
        .up_req (up_req),
        .dn_req (dn_req),
        .last   (last),
        .gnt    (arb_gnt)
    );

    assign len_sel = (served == REQ_UP) ? up_len : dn_len;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (up_req || dn_req) state_nxt = ST_GRANT;
            ST_GRANT: state_nxt = (len_sel == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (remaining == LEN_W'(1) || abort_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Winner is captured on leaving IDLE so gnt, len and direction all refer to it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            served    <= REQ_UP;
            last      <= REQ_DN;
            dir_up    <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_gnt != 2'b00) served <= arb_gnt[1] ? REQ_DN : REQ_UP;
                end
                ST_GRANT: begin
                    remaining <= len_sel;
                    dir_up    <= (served == REQ_UP);
                end
                ST_RUN:  remaining <= remaining - LEN_W'(1);
                ST_DONE: last <= served;
                default: ;
            endcase
        end
    end

    always_comb begin
        up_gnt    = (state == ST_GRANT) && (served == REQ_UP);
        dn_gnt    = (state == ST_GRANT) && (served == REQ_DN);
        up_done   = (state == ST_DONE)  && (served == REQ_UP);
        dn_done   = (state == ST_DONE)  && (served == REQ_DN);
        step_en   = (state == ST_RUN);
        step_up   = (state == ST_RUN) && dir_up;
        wrap      = step_en && ((step_up && cnt_val == MSB'(N - 1)) ||
                                (!step_up && cnt_val == '0));
        dbg_state = state;
    end

endmodule

// File: tb/tb_modn_step_scheduler.sv
// Scoreboard bench for modn_step_scheduler; abort scenario built with MODN_SCHED_ABORT_EN.
module tb_modn_step_scheduler;

  localparam int N = 10;
  localparam int MSB = 4;
  localparam int LEN_W = 4;
  localparam int W = 12;

  // events: {cycle[7:0], kind[3:0]}
  localparam int K_UP_GNT = 1, K_DN_GNT = 2, K_UP_DONE = 3, K_DN_DONE = 4;
  localparam int K_UP_STEP = 5, K_UP_WRAP = 6, K_DN_STEP = 7, K_DN_WRAP = 8;
  localparam int K_BAD_WRAP = 14, K_MULTI = 15;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic up_req = 1'b0, dn_req = 1'b0;
  logic [LEN_W-1:0] up_len = '0, dn_len = '0;
  logic [MSB-1:0] cnt = '0;
  logic cnt_ld = 1'b0;
  logic [MSB-1:0] cnt_ld_val = '0;
  logic abort = 1'b0;
  logic up_gnt, dn_gnt, up_done, dn_done, step_en, step_up, wrap;
  logic [1:0] dbg_state;

  int cyc = 0;
  int base = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  modn_step_scheduler #(.N(N), .MSB(MSB), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .up_req(up_req),
    .dn_req(dn_req),
    .up_len(up_len),
    .dn_len(dn_len),
    .cnt_val(cnt),
`ifdef MODN_SCHED_ABORT_EN
    .abort(abort),
`endif
    .up_gnt(up_gnt),
    .dn_gnt(dn_gnt),
    .up_done(up_done),
    .dn_done(dn_done),
    .step_en(step_en),
    .step_up(step_up),
    .wrap(wrap),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // counter under control of the scheduler
  always @(posedge clk) begin
    if (cnt_ld) cnt <= cnt_ld_val;
    else if (step_en) begin
      if (step_up) cnt <= (cnt == MSB'(N - 1)) ? '0 : cnt + 1'b1;
      else         cnt <= (cnt == '0) ? MSB'(N - 1) : cnt - 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // monitor: one observed event per cycle compared against the scoreboard
  always @(negedge clk) begin
    int nev;
    logic [3:0] kind;
    logic [W-1:0] got;
    nev = int'(up_gnt) + int'(dn_gnt) + int'(up_done) + int'(dn_done) + int'(step_en);
    kind = 4'd0;
    if (nev > 1) kind = 4'(K_MULTI);
    else if (up_gnt) kind = 4'(K_UP_GNT);
    else if (dn_gnt) kind = 4'(K_DN_GNT);
    else if (up_done) kind = 4'(K_UP_DONE);
    else if (dn_done) kind = 4'(K_DN_DONE);
    else if (step_en) begin
      if (step_up) kind = wrap ? 4'(K_UP_WRAP) : 4'(K_UP_STEP);
      else         kind = wrap ? 4'(K_DN_WRAP) : 4'(K_DN_STEP);
    end else if (wrap) kind = 4'(K_BAD_WRAP);
    if (kind != 4'd0) begin
      got = {8'(cyc - base), kind};
      if (exp_q.size() == 0) check_eq("unexpected_event", 32'(got), 32'd0);
      else check_eq("event", 32'(got), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic push_ev(input int t, input int kind);
    exp_q.push_back({8'(t), 4'(kind)});
  endtask

  task automatic push_burst(input bit is_up, input int len, inout int c, input int tg);
    bit w;
    push_ev(tg, is_up ? K_UP_GNT : K_DN_GNT);
    for (int i = 0; i < len; i++) begin
      w = is_up ? (c == N - 1) : (c == 0);
      if (is_up) push_ev(tg + 1 + i, w ? K_UP_WRAP : K_UP_STEP);
      else       push_ev(tg + 1 + i, w ? K_DN_WRAP : K_DN_STEP);
      c = is_up ? (c + 1) % N : (c + N - 1) % N;
    end
    push_ev(tg + len + 1, is_up ? K_UP_DONE : K_DN_DONE);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_cnt(input int v);
    @(negedge clk);
    cnt_ld = 1'b1;
    cnt_ld_val = MSB'(v);
    @(negedge clk);
    cnt_ld = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    check_eq("rst_outs", 32'({up_gnt, dn_gnt, up_done, dn_done, step_en, step_up, wrap}), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic run_single(input bit is_up, input int len, input int start);
    int c;
    load_cnt(start);
    c = start;
    @(negedge clk);
    base = cyc;
    if (is_up) begin up_req = 1'b1; up_len = LEN_W'(len); end
    else       begin dn_req = 1'b1; dn_len = LEN_W'(len); end
    push_burst(is_up, len, c, 1);
    @(negedge clk);
    up_req = 1'b0;
    dn_req = 1'b0;
    @(negedge clk);
    up_len = LEN_W'($urandom_range(0, 15));
    dn_len = LEN_W'($urandom_range(0, 15));
    drain(40);
  endtask

  initial begin
    int c;
    do_reset();

    // single up burst with wrap on second step
    run_single(1'b1, 3, 8);
    // zero length down burst
    run_single(1'b0, 0, 4);
    // down wrap on first step
    run_single(1'b0, 2, 0);

    // contention from reset: up, dn, up
    do_reset();
    load_cnt(5);
    c = 5;
    @(negedge clk);
    base = cyc;
    up_req = 1'b1; dn_req = 1'b1; up_len = 4'd1; dn_len = 4'd2;
    push_burst(1'b1, 1, c, 1);
    push_burst(1'b0, 2, c, 5);
    push_burst(1'b1, 1, c, 10);
    repeat (10) @(negedge clk);
    up_req = 1'b0; dn_req = 1'b0;
    drain(20);

    // random single bursts
    for (int i = 0; i < 5; i++) begin
      run_single(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, N - 1));
    end

    // reset during the second step of a 5-step burst
    load_cnt(3);
    c = 3;
    @(negedge clk);
    base = cyc;
    up_req = 1'b1; up_len = 4'd5;
    push_ev(1, K_UP_GNT);
    push_ev(2, K_UP_STEP);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b0;
    up_req = 1'b0;
    #1;
    check_eq("rst_run_step_en", 32'(step_en), 32'd0);
    check_eq("rst_run_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    drain(10);
    @(negedge clk);
    base = cyc;
    up_req = 1'b1; dn_req = 1'b1; up_len = 4'd0; dn_len = 4'd0;
    push_burst(1'b1, 0, c, 1);
    @(negedge clk);
    up_req = 1'b0; dn_req = 1'b0;
    drain(10);

`ifdef MODN_SCHED_ABORT_EN
    // abort after 2 of 6 steps
    load_cnt(2);
    c = 2;
    @(negedge clk);
    base = cyc;
    up_req = 1'b1; up_len = 4'd6;
    push_burst(1'b1, 2, c, 1);
    @(negedge clk);
    up_req = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain(20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/modn_step_scheduler.md
MODN_STEP_SCHEDULER -- requirements
Module: modn_step_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning the modulus of the controlled counter (N >= 2).
REQ-002 The block SHALL have parameter MSB, default 4, meaning the counter value width in bits (2^MSB >= N).
REQ-003 The block SHALL have parameter LEN_W, default 4, meaning the burst-length field width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port arst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have ports up_req and dn_req, input, 1 bit each, meaning the increment and decrement requesters hold a burst request.
REQ-007 The block SHALL have ports up_len and dn_len, input, LEN_W bits each, meaning the step count of each burst; sampled at grant.
REQ-008 The block SHALL have ports up_gnt and dn_gnt, output, 1 bit each, meaning a one-cycle grant pulse.
REQ-009 The block SHALL have ports up_done and dn_done, output, 1 bit each, meaning a one-cycle burst-complete pulse.
REQ-010 The block SHALL have port cnt_val, input, MSB bits, meaning the current counter value.
REQ-011 The block SHALL have ports step_en and step_up, output, 1 bit each, meaning counter step enable and direction (1 = +1 mod N, 0 = -1 mod N).
REQ-012 The block SHALL have port wrap, output, 1 bit, meaning the issued step crosses N-1->0 (up) or 0->N-1 (down).

Function
REQ-013 FSM states SHALL be IDLE, GRANT, RUN and DONE.
REQ-014 IDLE->GRANT SHALL occur when either req is high; the winner is chosen by 2-way round-robin: the requester not served last wins when both are high.
REQ-015 In GRANT, the block SHALL pulse the winner's gnt, latch its len into remaining and latch direction; next state is RUN, or DONE if len == 0.
REQ-016 In RUN, the block SHALL assert step_en every cycle with step_up equal to the latched direction, decrement remaining, and go to DONE after the cycle in which remaining == 1 (exactly len steps).
REQ-017 In DONE, the block SHALL pulse the served requester's done, update the last-served pointer and return to IDLE; the first new grant is no earlier than one cycle after done.
REQ-018 wrap SHALL be combinational and equal step_en & ((step_up & cnt_val == N-1) | (!step_up & cnt_val == 0)).
REQ-019 Requests are level-sensitive; a req deasserted during RUN SHALL NOT stop the burst, and len changes after GRANT SHALL be ignored.
REQ-020 step_en, gnt and done SHALL be low in IDLE; at most one gnt and one done SHALL be high in any cycle.

Reset
REQ-021 On arst_n low, the block SHALL go immediately to IDLE with step_en, step_up, gnt, done and remaining at 0, and the last-served pointer at dn (up wins first).
REQ-022 Reset during RUN SHALL abandon the burst without a done pulse.

Configuration
REQ-023 With MODN_SCHED_ABORT_EN defined, the block SHALL add input abort (1 bit); abort high in RUN SHALL deassert step_en from the next cycle, enter DONE and pulse done; abort outside RUN is ignored.
REQ-024 Without MODN_SCHED_ABORT_EN, the abort port SHALL be absent and every burst SHALL complete in full.

Structure
REQ-025 Package modn_sched_pkg SHALL hold the FSM state enum, the requester-id typedef (REQ_UP, REQ_DN) and state encodings.
REQ-026 The round-robin choice SHALL be the sub-module modn_rr_arb (two req inputs, last-served input, one-hot grant output).

Verification
REQ-027 Single up burst: N=10, cnt_val=8, up_req with up_len=3 -> up_gnt at cycle 1, three step_en with step_up=1, wrap on the second step (cnt_val 9), up_done one cycle after the last step.
REQ-028 Contention: both req high from reset -> up is served first, then dn; with both held, grants alternate up, dn, up.
REQ-029 Zero length: dn_req with dn_len=0 -> dn_gnt then dn_done on the next cycle, no step_en.
REQ-030 Down wrap: cnt_val=0, dn_len=2 -> wrap on the first step only, and step_up=0 on both steps.
REQ-031 Reset in RUN: arst_n low during the second step of a 5-step burst -> step_en drops immediately, no done pulse, and up wins the next contention.
REQ-032 Abort (MODN_SCHED_ABORT_EN): abort pulsed after 2 of 6 steps -> exactly 2 or 3 step_en (one cycle latency, fixed per REQ-023), then a done pulse.
